// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants, types and helpers for the UART receive path.
//   DEPTH_DEFAULT  default receive FIFO depth (power of two)
//   ENTRY_W        stored entry width: {parity_err, frame_err, data[7:0]}
//   TRIG_LVL_*     receive FIFO trigger levels selected by fcr_trig
//   trig_level()   fcr_trig -> trigger level in entries
//   timeout_limit() lcr -> character timeout in baud ticks (4 char times)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int ENTRY_W       = 10;

    localparam int TRIG_LVL_1  = 1;
    localparam int TRIG_LVL_4  = 4;
    localparam int TRIG_LVL_8  = 8;
    localparam int TRIG_LVL_14 = 14;

    typedef struct packed {
        logic       pe;
        logic       fe;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } trig_sel_e;

    function automatic logic [4:0] trig_level(input logic [1:0] sel);
        case (trig_sel_e'(sel))
            TRIG_1:  return 5'(TRIG_LVL_1);
            TRIG_4:  return 5'(TRIG_LVL_4);
            TRIG_8:  return 5'(TRIG_LVL_8);
            default: return 5'(TRIG_LVL_14);
        endcase
    endfunction

    // Only lcr[3:0] shape the character: [1:0] word length - 5,
    // [2] extra stop bit, [3] parity enable.
    function automatic logic [5:0] timeout_limit(input logic [3:0] lcr_lo);
        logic [5:0] char_bits;
        // 6 = start bit + the 5-bit minimum word length
        char_bits = 6'd6 + 6'(lcr_lo[1:0]) + 6'(lcr_lo[3]) + (lcr_lo[2] ? 6'd2 : 6'd1);
        return char_bits << 2;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock circular FIFO: storage, read/write pointers, occupancy.
// The caller qualifies wr_i/rd_i (no write when full unless also reading,
// no read when empty); simultaneous wr_i and rd_i keep the count steady.
//   clk_i, rst_i       clock, synchronous active-high reset
//   clr_i              flush pointers and count
//   wr_i, din_i        push din_i at the tail
//   rd_i               drop the head entry
//   dout_o             head entry, zero when empty
//   count_o            entries held (0..DEPTH)
//   full_o, empty_o    occupancy flags
//   flags_o, valid_o   top FLAG_W bits of every slot plus a per-slot
//                      occupancy mask, for status summaries
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEFAULT,
    parameter  int W      = ENTRY_W,
    parameter  int FLAG_W = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic                          wr_i,
    input  logic                          rd_i,
    input  logic [W-1:0]                  din_i,
    output logic [W-1:0]                  dout_o,
    output logic [CW-1:0]                 count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0][FLAG_W-1:0]  flags_o,
    output logic [DEPTH-1:0]              valid_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_i, rd_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; stale words are never visible because
    // validity comes from the pointers and count, which are reset.
    always_ff @(posedge clk_i) begin
        if (wr_i) mem_q[wr_ptr_q] <= din_i;
    end

    // NOTE: combinational outputs get a default before any conditional
    // assignment so no path leaves them unassigned (no latches).
    always_comb begin
        logic [AW-1:0] off;
        off     = '0;
        valid_o = '0;
        flags_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, off} < count_q);
            flags_o[i] = mem_q[i][W-1 -: FLAG_W];
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receive FIFO with overrun, error summary, trigger level and
// character-timeout interrupt.
//   clk, rst                       clock, synchronous active-high reset
//   rbr, rbr_full                  received byte, one-cycle "char complete"
//   frame_err, parity_err          receiver error flags (frame_err may lead)
//   baud_tick                      one pulse per bit period
//   lcr                            line control (word length, parity, stop)
//   fcr_en, fcr_rx_clr, fcr_trig   FIFO enable, flush pulse, trigger select
//   rd_en, lsr_rd                  host reads of RBR and LSR
//   dout, dout_fe, dout_pe         head entry, zero when empty
//   count, data_ready              occupancy, count != 0
//   overrun, err_in_fifo           sticky overrun, any stored FE/PE
//   trig_hit, timeout_irq          trigger reached, character timeout
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rbr,
    input  logic       rbr_full,
    input  logic       frame_err,
    input  logic       parity_err,
    input  logic       baud_tick,
    input  logic [7:0] lcr,
    input  logic       fcr_en,
    input  logic       fcr_rx_clr,
    input  logic [1:0] fcr_trig,
    input  logic       rd_en,
    input  logic       lsr_rd,
    output logic [7:0] dout,
    output logic       dout_fe,
    output logic       dout_pe,
    output logic [4:0] count,
    output logic       data_ready,
    output logic       overrun,
    output logic       err_in_fifo,
    output logic       trig_hit,
    output logic       timeout_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    rx_entry_t               head, wr_entry;
    logic [DEPTH-1:0][1:0]   flags;
    logic [DEPTH-1:0]        valid;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic                    flush, pop, push, holding_full, ovr_set, err_any;
    logic                    fcr_en_q;
    logic                    fe_pend_q, fe_pend_d;
    logic                    overrun_q, overrun_d;
    logic [5:0]              tmo_q, tmo_d, tmo_limit;
    logic                    unused_lcr_hi;

    // Break/stick-parity/DLAB bits do not change the received frame length.
    assign unused_lcr_hi = ^lcr[7:4];

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .W      (ENTRY_W),
        .FLAG_W (2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (flush),
        .wr_i    (fifo_wr),
        .rd_i    (fifo_rd),
        .din_i   (wr_entry),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .flags_o (flags),
        .valid_o (valid)
    );

    always_comb begin
        // Toggling the FIFO enable flushes just like an explicit clear, and
        // a flush swallows any same-cycle write or pop.
        flush        = fcr_rx_clr | (fcr_en ^ fcr_en_q);
        pop          = rd_en & ~fifo_empty & ~flush;
        push         = rbr_full & ~flush;
        // With the FIFO disabled the store behaves as a single holding reg.
        holding_full = fcr_en ? fifo_full : ~fifo_empty;
        ovr_set      = push & holding_full & ~pop;
        // Overrun in FIFO mode drops the new byte; in holding mode the new
        // byte replaces the old one, done as a paired pop+push.
        fifo_wr      = push & (~ovr_set | ~fcr_en);
        fifo_rd      = pop | (ovr_set & ~fcr_en);

        wr_entry      = '0;
        wr_entry.pe   = parity_err;
        wr_entry.fe   = fe_pend_q | frame_err;
        wr_entry.data = rbr;

        fe_pend_d = (flush | rbr_full) ? 1'b0 : (fe_pend_q | frame_err);
        overrun_d = ovr_set ? 1'b1 : (lsr_rd ? 1'b0 : overrun_q);

        tmo_limit = timeout_limit(lcr[3:0]);
        tmo_d     = tmo_q;
        if (flush | push | pop) begin
            tmo_d = '0;
        end else if (baud_tick & fcr_en & ~fifo_empty & (tmo_q < tmo_limit)) begin
            tmo_d = tmo_q + 6'd1;
        end

        err_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            err_any = err_any | (valid[i] & (|flags[i]));
        end
    end

    always_ff @(posedge clk) begin
        fcr_en_q <= fcr_en;
        if (rst) begin
            fe_pend_q <= 1'b0;
            overrun_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            fe_pend_q <= fe_pend_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
        end
    end

    assign dout        = head.data;
    assign dout_fe     = head.fe;
    assign dout_pe     = head.pe;
    assign count       = 5'(fifo_count);
    assign data_ready  = ~fifo_empty;
    assign overrun     = overrun_q;
    assign err_in_fifo = err_any;
    assign trig_hit    = fcr_en & (count >= trig_level(fcr_trig));
    assign timeout_irq = (tmo_q == tmo_limit);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed scenarios followed by randomized traffic, every cycle compared
// against a queue-based reference model of the receive FIFO.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, rbr_full, frame_err, parity_err, baud_tick;
    logic [7:0] rbr, lcr;
    logic       fcr_en, fcr_rx_clr, rd_en, lsr_rd;
    logic [1:0] fcr_trig;
    logic [7:0] dout;
    logic       dout_fe, dout_pe, data_ready, overrun, err_in_fifo, trig_hit, timeout_irq;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0] mq[$];
    bit         m_fe_pend, m_ovr, m_en_prev;
    int         m_tmo;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rbr(rbr), .rbr_full(rbr_full),
        .frame_err(frame_err), .parity_err(parity_err), .baud_tick(baud_tick),
        .lcr(lcr), .fcr_en(fcr_en), .fcr_rx_clr(fcr_rx_clr), .fcr_trig(fcr_trig),
        .rd_en(rd_en), .lsr_rd(lsr_rd), .dout(dout), .dout_fe(dout_fe),
        .dout_pe(dout_pe), .count(count), .data_ready(data_ready),
        .overrun(overrun), .err_in_fifo(err_in_fifo), .trig_hit(trig_hit),
        .timeout_irq(timeout_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lvl_of(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 14;
        endcase
    endfunction

    function automatic int limit_of(input logic [7:0] l);
        int word_len, stop_bits;
        word_len  = 5 + int'(l[1:0]);
        stop_bits = l[2] ? 2 : 1;
        return 4 * (1 + word_len + int'(l[3]) + stop_bits);
    endfunction

    task automatic model_update();
        int         occ;
        bit         flush, did_pop, set_ovr;
        logic [9:0] e;
        if (rst) begin
            mq.delete();
            m_fe_pend = 0;
            m_ovr     = 0;
            m_tmo     = 0;
            m_en_prev = fcr_en;
            return;
        end
        flush     = fcr_rx_clr || (fcr_en != m_en_prev);
        m_en_prev = fcr_en;
        occ       = mq.size();
        set_ovr   = 0;
        if (flush) begin
            mq.delete();
            m_fe_pend = 0;
            m_tmo     = 0;
            if (lsr_rd) m_ovr = 0;
            return;
        end
        did_pop = rd_en && (occ > 0);
        if (rbr_full) begin
            e = {parity_err, m_fe_pend | frame_err, rbr};
            if (did_pop) begin
                void'(mq.pop_front());
                mq.push_back(e);
            end else if (occ < (fcr_en ? DEPTH : 1)) begin
                mq.push_back(e);
            end else begin
                set_ovr = 1;
                if (!fcr_en) mq[0] = e;
            end
        end else if (did_pop) begin
            void'(mq.pop_front());
        end
        m_fe_pend = rbr_full ? 1'b0 : (m_fe_pend | frame_err);
        if (rbr_full || did_pop) m_tmo = 0;
        else if (baud_tick && fcr_en && occ > 0 && m_tmo < limit_of(lcr)) m_tmo++;
        if (set_ovr) m_ovr = 1;
        else if (lsr_rd) m_ovr = 0;
    endtask

    task automatic compare_all();
        logic [9:0] head;
        bit         err;
        head = (mq.size() != 0) ? mq[0] : 10'h0;
        err  = 0;
        foreach (mq[i]) if (mq[i][9:8] != 2'b00) err = 1;
        check("count",       32'(count),       32'(mq.size()));
        check("data_ready",  32'(data_ready),  32'(mq.size() != 0));
        check("overrun",     32'(overrun),     32'(m_ovr));
        check("dout",        32'(dout),        32'(head[7:0]));
        check("dout_fe",     32'(dout_fe),     32'(head[8]));
        check("dout_pe",     32'(dout_pe),     32'(head[9]));
        check("err_in_fifo", 32'(err_in_fifo), 32'(err));
        check("trig_hit",    32'(trig_hit),    32'(fcr_en && mq.size() >= lvl_of(fcr_trig)));
        check("timeout_irq", 32'(timeout_irq), 32'(m_tmo == limit_of(lcr)));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
        rst        = 1'b0;
        rbr_full   = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        baud_tick  = 1'b0;
        fcr_rx_clr = 1'b0;
        rd_en      = 1'b0;
        lsr_rd     = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        rbr      = d;
        rbr_full = 1'b1;
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        rst = 1'b1; rbr = 8'h00; rbr_full = 1'b0; frame_err = 1'b0; parity_err = 1'b0;
        baud_tick = 1'b0; lcr = 8'h03; fcr_en = 1'b1; fcr_rx_clr = 1'b0; fcr_trig = 2'b00;
        rd_en = 1'b0; lsr_rd = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Reset state
        check("rst_count",  32'(count), 0);
        check("rst_ready",  32'(data_ready), 0);
        check("rst_dout",   32'(dout), 0);
        check("rst_ovr",    32'(overrun), 0);
        check("rst_err",    32'(err_in_fifo), 0);
        check("rst_tmo",    32'(timeout_irq), 0);
        check("rst_trig",   32'(trig_hit), 0);
        step();

        // Basic ordering
        push(8'h41); push(8'h42); push(8'h43);
        check("ord_dout0", 32'(dout), 32'h41);
        check("ord_count", 32'(count), 3);
        pop(); check("ord_dout1", 32'(dout), 32'h42);
        pop(); check("ord_dout2", 32'(dout), 32'h43);
        pop();
        check("ord_empty", 32'(count), 0);
        check("ord_ready", 32'(data_ready), 0);

        // Overflow: 17th byte dropped
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
        check("ovf_count", 32'(count), 16);
        check("ovf_flag",  32'(overrun), 1);
        check("ovf_head",  32'(dout), 32'h10);
        lsr_rd = 1'b1; step();
        check("ovf_clr",   32'(overrun), 0);

        // Full with simultaneous write and pop
        rbr = 8'hAA; rbr_full = 1'b1; rd_en = 1'b1; step();
        check("full_wr_rd_count", 32'(count), 16);
        check("full_wr_rd_ovr",   32'(overrun), 0);
        for (int i = 1; i < 16; i++) begin
            check("full_drain", 32'(dout), 32'(8'h10 + i));
            pop();
        end
        check("full_tail", 32'(dout), 32'hAA);
        pop();
        check("full_empty", 32'(count), 0);

        // Flush beats a same-cycle write
        push(8'h01);
        rbr = 8'h77; rbr_full = 1'b1; fcr_rx_clr = 1'b1; step();
        check("flush_count", 32'(count), 0);
        check("flush_ovr",   32'(overrun), 0);

        // Frame error leads rbr_full; parity error rides with it
        frame_err = 1'b1; step();
        push(8'h55);
        check("fe_flag", 32'(dout_fe), 1);
        check("fe_err",  32'(err_in_fifo), 1);
        pop();
        check("fe_clear", 32'(err_in_fifo), 0);
        parity_err = 1'b1; push(8'h66);
        check("pe_flag", 32'(dout_pe), 1);
        check("pe_fe",   32'(dout_fe), 0);
        pop();

        // Trigger level 4
        fcr_trig = 2'b01;
        push(8'h01); push(8'h02); push(8'h03);
        check("trig_3", 32'(trig_hit), 0);
        push(8'h04);
        check("trig_4", 32'(trig_hit), 1);
        pop();
        check("trig_pop", 32'(trig_hit), 0);
        pop(); pop(); pop();
        fcr_trig = 2'b00;

        // Character timeout, 8N1 -> 40 ticks
        lcr = 8'h03;
        push(8'h33);
        for (int i = 0; i < 39; i++) begin
            baud_tick = 1'b1; step();
        end
        check("tmo_39", 32'(timeout_irq), 0);
        baud_tick = 1'b1; step();
        check("tmo_40", 32'(timeout_irq), 1);
        pop();
        check("tmo_pop", 32'(timeout_irq), 0);

        // Holding-register mode
        fcr_en = 1'b0; step();
        push(8'hA1); push(8'hA2);
        check("hold_count", 32'(count), 1);
        check("hold_dout",  32'(dout), 32'hA2);
        check("hold_ovr",   32'(overrun), 1);
        lsr_rd = 1'b1; step();
        pop();
        fcr_en = 1'b1; step();

        // Reset mid-operation
        push(8'h11); push(8'h22); push(8'h33);
        rst = 1'b1; step();
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_ready", 32'(data_ready), 0);
        step();

        // Randomized traffic in three phases: fill, drain, idle-with-ticks
        for (int i = 0; i < 3000; i++) begin
            mode       = (i / 250) % 3;
            rbr        = 8'($urandom);
            frame_err  = ($urandom_range(0, 99) < 10);
            parity_err = ($urandom_range(0, 99) < 10);
            lsr_rd     = ($urandom_range(0, 99) < 5);
            fcr_rx_clr = ($urandom_range(0, 299) == 0);
            case (mode)
                0: begin
                    rbr_full  = ($urandom_range(0, 99) < 50);
                    rd_en     = ($urandom_range(0, 99) < 20);
                    baud_tick = ($urandom_range(0, 99) < 40);
                end
                1: begin
                    rbr_full  = ($urandom_range(0, 99) < 20);
                    rd_en     = ($urandom_range(0, 99) < 50);
                    baud_tick = ($urandom_range(0, 99) < 40);
                end
                default: begin
                    rbr_full  = ($urandom_range(0, 199) == 0);
                    rd_en     = ($urandom_range(0, 199) == 0);
                    baud_tick = 1'b1;
                end
            endcase
            if ($urandom_range(0, 399) == 0) fcr_en = ~fcr_en;
            if ($urandom_range(0, 149) == 0) lcr = 8'($urandom);
            if ($urandom_range(0, 99) == 0)  fcr_trig = 2'($urandom);
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
